audio_dac_out: RTL and testbench

Sample sink and output stage for the audio path. Accepts stereo unsigned samples from a channel or mixer over a valid/ready handshake and buffers them in a small FIFO. Consumes one sample pair per fixed sample period and drives the 4-bit `audio_l`/`audio_r` pins through a per-clock first-order sigma-delta modulator, so more than 4 bits of amplitude reach the analog side.

---
 rtl/audio_dac_out.sv | 238 +++++++++++++++++++++++
 tb/tb_audio_dac_out.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_out.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// audio_dac_out
//
// Stereo sample sink and 4-bit DAC output stage. Sample pairs arrive over a
// valid/ready handshake and are held in a small FIFO. One pair is consumed
// every RATE_DIV clocks. Each channel drives a 4-bit pin through a per-clock
// first-order sigma-delta modulator, so that more than 4 bits of amplitude
// reach the analog side.
//
// Configuration macro:
//   AUDIO_DAC_DITHER_EN  defined     : first-order sigma-delta modulator
//                        not defined : plain truncation to the top 4 bits
//
// Ports:
//   clk           rising-edge clock for every register
//   rstn          asynchronous active-low reset
//   in_valid      a sample pair is present on in_l/in_r
//   in_ready      FIFO can accept a pair (registered, equals !full)
//   in_l, in_r    unsigned offset-binary samples, WIDTH bits
//   clr_underrun  synchronous clear of underrun
//   underrun      sticky: a sample tick found the FIFO empty
//   fifo_level    current FIFO occupancy
//   audio_l/_r    registered 4-bit DAC codes
// ---------------------------------------------------------------------------
module audio_dac_out #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RATE_DIV   = 128
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_l,
  input  logic [WIDTH-1:0]              in_r,
  input  logic                          clr_underrun,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [3:0]                    audio_l,
  output logic [3:0]                    audio_r
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = $clog2(RATE_DIV);
  localparam int unsigned EW = WIDTH - 4;
  localparam logic [DW-1:0] DIV_LAST = DW'(RATE_DIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  // FIFO storage and pointers
  logic [WIDTH-1:0] mem_l_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_l_d [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_r_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_r_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;

  // Rate divider
  logic [DW-1:0]    div_cnt_q, div_cnt_d;

  // Current sample and status
  logic [WIDTH-1:0] cur_l_q, cur_l_d;
  logic [WIDTH-1:0] cur_r_q, cur_r_d;
  logic             underrun_q, underrun_d;

  // Output codes
  logic [3:0]       audio_l_q, audio_l_d;
  logic [3:0]       audio_r_q, audio_r_d;

  logic             tick;
  logic             empty;
  logic             push;
  logic             pop;

  // -------------------------------------------------------------------------
  // Handshake, divider and FIFO control
  // -------------------------------------------------------------------------
  always_comb begin
    tick  = (div_cnt_q == DIV_LAST);
    empty = (level_q == '0);
    // Acceptance looks only at the registered full flag, so a pop in the
    // same cycle never makes room for a push into a full FIFO.
    push  = in_valid && !full_q;
    // Emptiness is judged at the start of the cycle; a same-cycle push
    // cannot satisfy the tick.
    pop   = tick && !empty;
  end

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
  end

  always_comb begin
    mem_l_d  = mem_l_q;
    mem_r_d  = mem_r_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      mem_l_d[wr_ptr_q] = in_l;
      mem_r_d[wr_ptr_q] = in_r;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase

    full_d = (level_d == LVL_FULL);
  end

  // -------------------------------------------------------------------------
  // Current sample and underrun
  // -------------------------------------------------------------------------
  always_comb begin
    cur_l_d = cur_l_q;
    cur_r_d = cur_r_q;
    if (pop) begin
      cur_l_d = mem_l_q[rd_ptr_q];
      cur_r_d = mem_r_q[rd_ptr_q];
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (clr_underrun) begin
      underrun_d = 1'b0;
    end
    // A new underrun overrides a clear in the same cycle.
    if (tick && empty) begin
      underrun_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
`ifdef AUDIO_DAC_DITHER_EN
  logic [EW-1:0]  err_l_q, err_l_d;
  logic [EW-1:0]  err_r_q, err_r_d;
  logic [WIDTH:0] acc_l;
  logic [WIDTH:0] acc_r;

  // The carried residue is added to the sample each clock; the top nibble
  // goes out and the remainder carries forward. An overflow into the
  // extra bit saturates the code and drops the residue.
  always_comb begin
    acc_l = {1'b0, cur_l_q} + {5'b0, err_l_q};
    acc_r = {1'b0, cur_r_q} + {5'b0, err_r_q};

    if (acc_l[WIDTH]) begin
      audio_l_d = 4'hF;
      err_l_d   = '0;
    end else begin
      audio_l_d = acc_l[WIDTH-1:WIDTH-4];
      err_l_d   = acc_l[WIDTH-5:0];
    end

    if (acc_r[WIDTH]) begin
      audio_r_d = 4'hF;
      err_r_d   = '0;
    end else begin
      audio_r_d = acc_r[WIDTH-1:WIDTH-4];
      err_r_d   = acc_r[WIDTH-5:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_l_q <= '0;
      err_r_q <= '0;
    end else begin
      err_l_q <= err_l_d;
      err_r_q <= err_r_d;
    end
  end
`else
  logic unused_cur_lsbs;

  always_comb begin
    audio_l_d       = cur_l_q[WIDTH-1:WIDTH-4];
    audio_r_d       = cur_r_q[WIDTH-1:WIDTH-4];
    unused_cur_lsbs = ^{cur_l_q[WIDTH-5:0], cur_r_q[WIDTH-5:0]};
  end
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_l_q[i] <= '0;
        mem_r_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      div_cnt_q  <= '0;
      cur_l_q    <= '0;
      cur_r_q    <= '0;
      underrun_q <= 1'b0;
      audio_l_q  <= '0;
      audio_r_q  <= '0;
    end else begin
      mem_l_q    <= mem_l_d;
      mem_r_q    <= mem_r_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      div_cnt_q  <= div_cnt_d;
      cur_l_q    <= cur_l_d;
      cur_r_q    <= cur_r_d;
      underrun_q <= underrun_d;
      audio_l_q  <= audio_l_d;
      audio_r_q  <= audio_r_d;
    end
  end

  always_comb begin
    in_ready   = !full_q;
    underrun   = underrun_q;
    fifo_level = level_q;
    audio_l    = audio_l_q;
    audio_r    = audio_r_q;
  end

endmodule

// File: tb/tb_audio_dac_out.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_audio_dac_out
//
// Self-checking bench for audio_dac_out. A table of sample pairs fills the
// FIFO back-to-back; accepted pairs go to a scoreboard queue and are compared
// against the DAC codes after each sample tick. Hand-written sequences cover
// reset/idle, the dither pattern, saturation, the underrun/clear race and a
// reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_audio_dac_out;

  localparam int unsigned W  = 16;
  localparam int unsigned FD = 4;
  localparam int unsigned RD = 16;
  localparam int unsigned LW = $clog2(FD) + 1;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_l;
  logic [W-1:0]  in_r;
  logic          clr_underrun;
  logic          underrun;
  logic [LW-1:0] fifo_level;
  logic [3:0]    audio_l;
  logic [3:0]    audio_r;

  audio_dac_out #(
    .WIDTH      (W),
    .FIFO_DEPTH (FD),
    .RATE_DIV   (RD)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_l         (in_l),
    .in_r         (in_r),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .audio_l      (audio_l),
    .audio_r      (audio_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] l;
    logic [3:0] r;
  } exp_t;

  typedef struct {
    logic [W-1:0]  l;
    logic [W-1:0]  r;
    logic          rdy_before;
    logic [LW-1:0] level_after;
    logic          rdy_after;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[5];
  int unsigned n_vec;
  int unsigned n_miss;
  int unsigned cyc;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Advance until the next active edge is a sample tick.
  task automatic to_pre_tick();
    int unsigned g = 0;
    while (((cyc % RD) != RD - 1) && (g < 2 * RD)) begin
      step();
      g++;
    end
    if ((cyc % RD) != RD - 1) begin
      n_vec++;
      n_miss++;
      $display("FAIL tick_wait: no tick within %0d cycles", 2 * RD);
    end
  endtask

  // Called a couple of ns after an edge; pulses rstn between edges.
  task automatic pulse_reset();
    #2;
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    cyc  = 0;
    sb.delete();
  endtask

  // Tick edge followed by the edge at which the popped pair is visible.
  task automatic tick_pop(input string name);
    exp_t e;
    to_pre_tick();
    step();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      step();
      chk({name, "_l"}, audio_l, e.l);
      chk({name, "_r"}, audio_r, e.r);
    end else begin
      chk({name, "_underrun"}, underrun, 1'b1);
    end
  endtask

  initial begin
    exp_t       e;
    logic [3:0] exp_dl;

    vt[0] = '{16'h1000, 16'h2000, 1'b1, 3'd1, 1'b1};
    vt[1] = '{16'h3000, 16'h4000, 1'b1, 3'd2, 1'b1};
    vt[2] = '{16'h5000, 16'h6000, 1'b1, 3'd3, 1'b1};
    vt[3] = '{16'h7000, 16'hA000, 1'b1, 3'd4, 1'b0};
    vt[4] = '{16'hB000, 16'hC000, 1'b0, 3'd4, 1'b0};

    n_vec        = 0;
    n_miss       = 0;
    cyc          = 0;
    rstn         = 1'b0;
    in_valid     = 1'b0;
    in_l         = '0;
    in_r         = '0;
    clr_underrun = 1'b0;

    // Reset and idle
    #12;
    chk("rst_audio_l", audio_l, 4'h0);
    chk("rst_audio_r", audio_r, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_level", fifo_level, '0);
    chk("rst_underrun", underrun, 1'b0);
    #10;
    rstn = 1'b1;
    cyc  = 0;
    for (int i = 0; i < RD - 1; i++) begin
      step();
      chk("idle_audio", {audio_l, audio_r}, 8'h00);
    end
    chk("idle_underrun_pre_tick", underrun, 1'b0);
    step();
    chk("idle_underrun_first_tick", underrun, 1'b1);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_audio_tick", {audio_l, audio_r}, 8'h00);

    // Dither pattern
    pulse_reset();
    in_l     = 16'h8800;
    in_r     = 16'h8000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("dither_level", fifo_level, 3'd1);
    to_pre_tick();
    step();
    chk("dither_old_audio", audio_l, 4'h0);
    chk("dither_level_pop", fifo_level, 3'd0);
    for (int i = 0; i < 6; i++) begin
      step();
`ifdef AUDIO_DAC_DITHER_EN
      exp_dl = ((i % 2) == 0) ? 4'h8 : 4'h9;
`else
      exp_dl = 4'h8;
`endif
      chk("dither_l", audio_l, exp_dl);
      chk("dither_r", audio_r, 4'h8);
    end

    // Saturation
    pulse_reset();
    in_l     = 16'hFFFF;
    in_r     = 16'hFFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    to_pre_tick();
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("sat_l", audio_l, 4'hF);
      chk("sat_r", audio_r, 4'hF);
    end

    // Full FIFO: five back-to-back pushes, table driven
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      in_l     = vt[i].l;
      in_r     = vt[i].r;
      in_valid = 1'b1;
      chk("full_rdy_before", in_ready, vt[i].rdy_before);
      if (vt[i].rdy_before) begin
        e.l = vt[i].l[W-1:W-4];
        e.r = vt[i].r[W-1:W-4];
        sb.push_back(e);
      end
      step();
      chk("full_level", fifo_level, vt[i].level_after);
      chk("full_rdy_after", in_ready, vt[i].rdy_after);
    end
    in_valid = 1'b0;
    to_pre_tick();
    step();
    chk("full_level_after_pop", fifo_level, 3'd3);
    chk("full_rdy_after_pop", in_ready, 1'b1);
    e = sb.pop_front();
    step();
    chk("pop0_l", audio_l, e.l);
    chk("pop0_r", audio_r, e.r);
    for (int i = 0; i < 3; i++) begin
      tick_pop("pop_order");
    end
    chk("drain_level", fifo_level, 3'd0);
    chk("drain_underrun", underrun, 1'b0);

    // Underrun/clear race, with a push on the same empty tick
    to_pre_tick();
    clr_underrun = 1'b1;
    in_l         = 16'hD000;
    in_r         = 16'hE000;
    in_valid     = 1'b1;
    step();
    clr_underrun = 1'b0;
    in_valid     = 1'b0;
    e.l = 4'hD;
    e.r = 4'hE;
    sb.push_back(e);
    chk("race_underrun", underrun, 1'b1);
    chk("race_level", fifo_level, 3'd1);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk("late_clear_underrun", underrun, 1'b0);
    tick_pop("late_push");
    chk("late_push_underrun", underrun, 1'b0);

    // Reset mid-stream
    in_valid = 1'b1;
    in_l = 16'h4000; in_r = 16'h5000; step();
    in_l = 16'h6000; in_r = 16'h7000; step();
    in_l = 16'h9000; in_r = 16'h3000; step();
    in_valid = 1'b0;
    chk("mid_level", fifo_level, 3'd3);
    chk("mid_audio_nonzero", audio_l, 4'hD);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_audio_l", audio_l, 4'h0);
    chk("mid_rst_audio_r", audio_r, 4'h0);
    chk("mid_rst_level", fifo_level, 3'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    rstn = 1'b1;
    cyc  = 0;
    sb.delete();
    for (int i = 0; i < RD - 1; i++) begin
      step();
    end
    chk("mid_div_pre_tick", underrun, 1'b0);
    step();
    chk("mid_div_restart", underrun, 1'b1);
    chk("mid_audio_after", {audio_l, audio_r}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
